// File: rtl/datapath_pkg.sv
// Shared opcodes, instruction field positions, FSM states and decoded-instruction record
// for the register-file / ALU / RAM datapath sequencer.
package datapath_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ALU   = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_HALT  = 4'd4;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;
  localparam int RD_MSB = 27;
  localparam int RD_LSB = 23;
  localparam int RA_MSB = 22;
  localparam int RA_LSB = 18;
  localparam int RB_MSB = 17;
  localparam int RB_LSB = 13;
  localparam int FS_MSB = 12;
  localparam int FS_LSB = 8;
  localparam int CO_BIT = 7;

  localparam logic [4:0] FS_PASS_A = 5'd0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXEC     = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_WB       = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [4:0] rd;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] fs;
    logic       co;
    logic       is_legal;
  } instr_fields_t;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational split of a 32-bit instruction word into its fields.
module instr_decode
  import datapath_pkg::*;
(
  input  logic [31:0]   instr,
  output instr_fields_t fields
);

  logic unused_bits;
  assign unused_bits = ^instr[6:0];

  always_comb begin
    fields          = '0;
    fields.op       = instr[OP_MSB:OP_LSB];
    fields.rd       = instr[RD_MSB:RD_LSB];
    fields.ra       = instr[RA_MSB:RA_LSB];
    fields.rb       = instr[RB_MSB:RB_LSB];
    fields.fs       = instr[FS_MSB:FS_LSB];
    fields.co       = instr[CO_BIT];
    fields.is_legal = (instr[OP_MSB:OP_LSB] <= OP_HALT);
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer: accepts one instruction at a time and steps the datapath
// through EXEC / MEM_WAIT / WB, producing control words and latching ALU flags.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  SIGNAL,
  output logic [4:0]  A,
  output logic [4:0]  B,
  output logic [4:0]  regSel,
  output logic        wrt,
  output logic [4:0]  FS,
  output logic        CO,
  output logic        RAMwrt,
  output logic        muxSelect,
  output logic [3:0]  status,
  output logic        done,
  output logic        illegal,
  output logic        halted
);

  localparam logic [1:0] WAIT_INIT = 2'(RAM_LATENCY - 1);

  state_t        state_q, state_d;
  instr_fields_t fields_q, fields_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [3:0]    status_q, status_d;
  instr_fields_t dec;

  instr_decode u_decode (
    .instr  (instr),
    .fields (dec)
  );

  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          fields_d = dec;
          state_d  = (dec.op == OP_HALT) ? ST_HALT : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (fields_q.op == OP_ALU) begin
          state_d  = ST_WB;
          status_d = SIGNAL;
        end else if (fields_q.op == OP_LOAD) begin
          state_d = ST_MEM_WAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        if (cnt_q == 2'd0) state_d = ST_WB;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_WB:   state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      fields_q <= '0;
      cnt_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  logic is_alu, is_load, is_store;
  assign is_alu   = (fields_q.op == OP_ALU);
  assign is_load  = (fields_q.op == OP_LOAD);
  assign is_store = (fields_q.op == OP_STORE);

  // Outputs decode from state only; reset forces every output low while it is high.
  always_comb begin
    instr_ready = 1'b0;
    A           = '0;
    B           = '0;
    regSel      = '0;
    wrt         = 1'b0;
    FS          = FS_PASS_A;
    CO          = 1'b0;
    RAMwrt      = 1'b0;
    muxSelect   = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    halted      = 1'b0;
    status      = reset ? 4'd0 : status_q;
    if (!reset) begin
      case (state_q)
        ST_IDLE: instr_ready = 1'b1;
        ST_EXEC, ST_MEM_WAIT, ST_WB: begin
          if (is_alu || is_load || is_store) A = fields_q.ra;
          if (is_alu) begin
            B  = fields_q.rb;
            FS = fields_q.fs;
            CO = fields_q.co;
          end
          if (is_store) B = fields_q.rb;
          if (state_q == ST_EXEC && !is_alu && !is_load) begin
            done    = 1'b1;
            illegal = !fields_q.is_legal;
            RAMwrt  = is_store;
          end
          if (state_q == ST_WB) begin
            regSel    = fields_q.rd;
            wrt       = 1'b1;
            done      = 1'b1;
            muxSelect = is_load;
          end
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench: directed and random instructions compared cycle by cycle
// against a timing/trace model derived from the instruction semantics.
module tb_datapath_sequencer;

  localparam int L = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  SIGNAL;
  logic [4:0]  A, B, regSel, FS;
  logic        wrt, CO, RAMwrt, muxSelect, done, illegal, halted;
  logic [3:0]  status;

  always #5 clock = ~clock;

  datapath_sequencer #(.RAM_LATENCY(L)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .SIGNAL      (SIGNAL),
    .A           (A),
    .B           (B),
    .regSel      (regSel),
    .wrt         (wrt),
    .FS          (FS),
    .CO          (CO),
    .RAMwrt      (RAMwrt),
    .muxSelect   (muxSelect),
    .status      (status),
    .done        (done),
    .illegal     (illegal),
    .halted      (halted)
  );

  typedef struct packed {
    logic       rdy;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] rs;
    logic       wrt;
    logic [4:0] fs;
    logic       co;
    logic       ramwrt;
    logic       mux;
    logic [3:0] st;
    logic       done;
    logic       ill;
    logic       hlt;
  } obs_t;

  int         tests = 0;
  int         fails = 0;
  logic [3:0] status_exp = 4'd0;

  function automatic obs_t sample();
    obs_t o;
    o.rdy = instr_ready; o.a = A; o.b = B; o.rs = regSel; o.wrt = wrt;
    o.fs = FS; o.co = CO; o.ramwrt = RAMwrt; o.mux = muxSelect;
    o.st = status; o.done = done; o.ill = illegal; o.hlt = halted;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t e);
    obs_t o;
    o = sample();
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int ra,
                                     input int rb, input int fs, input int co);
    logic [31:0] w;
    w        = $urandom;
    w[31:28] = 4'(op);
    w[27:23] = 5'(rd);
    w[22:18] = 5'(ra);
    w[17:13] = 5'(rb);
    w[12:8]  = 5'(fs);
    w[7]     = 1'(co);
    return w;
  endfunction

  // Cycles from accept to retirement: ALU EXEC+WB, LOAD EXEC+L waits+WB, others EXEC only.
  function automatic int latency(input logic [31:0] ins);
    int op;
    op = int'(ins[31:28]);
    if (op == 1) return 2;
    if (op == 2) return L + 2;
    return 1;
  endfunction

  function automatic obs_t idle_obs();
    obs_t e;
    e     = '0;
    e.rdy = 1'b1;
    e.st  = status_exp;
    return e;
  endfunction

  function automatic obs_t expect_step(input logic [31:0] ins, input int k, input int n);
    obs_t e;
    int   op;
    op   = int'(ins[31:28]);
    e    = '0;
    e.st = status_exp;
    if (op >= 1 && op <= 3) e.a = ins[22:18];
    if (op == 1) begin
      e.b  = ins[17:13];
      e.fs = ins[12:8];
      e.co = ins[7];
    end
    if (op == 3) e.b = ins[17:13];
    if (k == n) begin
      e.done = 1'b1;
      if (op == 1 || op == 2) begin
        e.rs  = ins[27:23];
        e.wrt = 1'b1;
        e.mux = (op == 2);
      end else begin
        e.ramwrt = (op == 3);
        e.ill    = (op >= 5);
      end
    end
    return e;
  endfunction

  task automatic run_instr(input logic [31:0] ins, input bit hold,
                           input logic [31:0] follow, input int abort_k, input string tag);
    int n;
    n = latency(ins);
    @(negedge clock);
    check({tag, ":ready"}, idle_obs());
    instr       = ins;
    instr_valid = 1'b1;
    SIGNAL      = 4'($urandom);
    @(posedge clock);
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      if (k == abort_k) begin
        reset = 1'b1;
        #1;
        check({tag, ":abort_now"}, '0);
        @(negedge clock);
        check({tag, ":abort_next"}, '0);
        reset       = 1'b0;
        instr_valid = 1'b0;
        status_exp  = 4'd0;
        return;
      end
      check($sformatf("%s:c%0d", tag, k), expect_step(ins, k, n));
      SIGNAL = 4'($urandom);
      if (ins[31:28] == 4'd1 && k == 1) status_exp = SIGNAL;
      if (!hold) begin
        instr_valid = 1'b0;
        instr       = $urandom;
      end else if (k == n) begin
        instr = follow;
      end
    end
    $display("[TB] %s op=%0d retired after %0d cycles", tag, ins[31:28], n);
  endtask

  task automatic run_halt();
    obs_t e;
    @(negedge clock);
    check("halt:ready", idle_obs());
    instr       = mk(4, 0, 0, 0, 0, 0);
    instr_valid = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      e     = '0;
      e.hlt = 1'b1;
      e.st  = status_exp;
      check($sformatf("halt:c%0d", k), e);
      instr  = mk(1, $urandom_range(0, 31), 1, 2, 3, 0);
      SIGNAL = 4'($urandom);
    end
    reset = 1'b1;
    #1;
    check("halt:reset_now", '0);
    @(negedge clock);
    check("halt:reset_next", '0);
    reset       = 1'b0;
    instr_valid = 1'b0;
    status_exp  = 4'd0;
    $display("[TB] halt held 20 cycles then reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w_alu, w_store, w_nop, w;
    int op;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    SIGNAL      = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset", '0);
    reset = 1'b0;
    $display("[TB] reset released");

    run_instr(mk(1, 3, 1, 2, 5, 1), 1'b0, 32'd0, 0, "alu");
    run_instr(mk(2, 7, 4, 0, 0, 0), 1'b0, 32'd0, 0, "load");
    run_instr(mk(3, 0, 9, 10, 0, 0), 1'b0, 32'd0, 0, "store");

    w_alu   = mk(1, 6, 11, 12, 17, 0);
    w_store = mk(3, 0, 21, 22, 0, 1);
    w_nop   = mk(0, 5, 5, 5, 5, 1);
    run_instr(w_alu, 1'b1, w_store, 0, "b2b_alu");
    run_instr(w_store, 1'b1, w_nop, 0, "b2b_store");
    run_instr(w_nop, 1'b0, 32'd0, 0, "b2b_nop");

    run_instr(mk(12, 3, 4, 5, 6, 1), 1'b0, 32'd0, 0, "illegal12");
    run_instr(mk(1, 9, 2, 3, 4, 1), 1'b0, 32'd0, 2, "rst_wb");

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 15);
      if (op == 4) op = 2;
      w = mk(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 1));
      run_instr(w, 1'($urandom_range(0, 1)), w, 0, $sformatf("rnd%0d", i));
      instr_valid = 1'b0;
    end

    run_halt();
    run_instr(mk(1, 1, 2, 3, 7, 0), 1'b0, 32'd0, 0, "post_halt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle control unit that drives the register-file / ALU / RAM datapath (`TopLevel`) from a stream of 32-bit instructions. It replaces free-running stimulus with decoded, correctly ordered control words: register selects, ALU function, write enables, and write-back mux select. It accepts one instruction at a time over a valid/ready handshake and captures ALU status flags.

## Interface
Parameters:
- `RAM_LATENCY`, default 1: cycles between RAM address presentation and valid `RAMo`. Legal range 1–3.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr`  in  32  instruction word. Fields: op[31:28], rd[27:23], ra[22:18], rb[17:13], fs[12:8], co[7]. Bits [6:0] are ignored.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `SIGNAL`  in  4  ALU status {V,C,N,Z}.
- `A`, `B`  out  5 each  register-file read selects.
- `regSel`  out  5  register-file write select.
- `wrt`  out  1  register-file write enable.
- `FS`  out  5  ALU function select.
- `CO`  out  1  ALU carry-in.
- `RAMwrt`  out  1  RAM write enable.
- `muxSelect`  out  1  write-back source: 0 = ALU, 1 = RAM.
- `status`  out  4  latched {V,C,N,Z}.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  pulse coincident with `done` for an undefined opcode.
- `halted`  out  1  high in the HALT state.

## Operation
- Opcodes:
  - 0 NOP
  - 1 ALU: rd ← ra FS rb
  - 2 LOAD: rd ← RAM[ra]
  - 3 STORE: RAM[ra] ← rb
  - 4 HALT
  - 5–15 are illegal and execute as NOP with `illegal` asserted.
- FSM states: IDLE, EXEC, MEM_WAIT, WB, HALT.
- IDLE: `instr_ready`=1. On accept (`instr_valid && instr_ready` at an edge), latch the instruction.
  - HALT opcode goes to the HALT state.
  - All other opcodes go to EXEC.
- EXEC drives:
  - ALU: `A`=ra, `B`=rb, `FS`=fs, `CO`=co, `muxSelect`=0. Next state WB. `status` ← `SIGNAL` on the exiting edge.
  - LOAD: `A`=ra, `FS`=FS_PASS_A, `CO`=0. Next state MEM_WAIT. `status` is not updated.
  - STORE: `A`=ra, `B`=rb, `FS`=FS_PASS_A, `RAMwrt`=1 for exactly this cycle. `done`=1. Next state IDLE.
  - NOP / illegal: no enables asserted. `done`=1 (and `illegal`=1 for an illegal opcode). Next state IDLE.
- MEM_WAIT: holds the EXEC outputs for RAM_LATENCY cycles (down-counter), then goes to WB.
- WB: holds `A`, `B`, `FS`, `CO` from EXEC. Drives `regSel`=rd, `wrt`=1, `done`=1, and `muxSelect`=1 for LOAD, 0 for ALU. Next state IDLE.
- HALT: `halted`=1, `instr_ready`=0, all enables 0. Only `reset` exits this state.
- Outputs not listed for a state are 0. `wrt` and `RAMwrt` are never asserted in the same cycle.

## Timing
- Reset (`reset` high at an edge) forces:
  - state = IDLE; `status`=0.
  - all outputs 0, including `instr_ready`, while `reset` is high.
  - `instr_ready` becomes 1 in the first cycle after `reset` is sampled low.
- Reset mid-instruction: the pending `wrt`/`RAMwrt` is dropped and the instruction is lost. No `done` is produced.
- Cycle counts, with accept at edge t:
  - ALU: EXEC in cycle t+1, WB in t+2, `instr_ready` again in t+3.
  - LOAD: EXEC t+1, MEM_WAIT t+2 … t+1+RAM_LATENCY, WB at t+2+RAM_LATENCY.
  - STORE / NOP / illegal: EXEC only, `done` in t+1, ready again in t+2.
- `instr_ready` is a function of state only, with no combinational path from `instr_valid`.
- `instr` only needs to be stable at the accept edge.
- `SIGNAL` is sampled only at the EXEC→WB edge of ALU instructions.

## Structure
- Package `datapath_pkg` holds:
  - opcode constants OP_NOP … OP_HALT
  - state enum
  - instruction field bit positions
  - FS_PASS_A = 5'd0
- Sub-module `instr_decode`: combinational split of `instr` into fields plus an is_legal flag. Sequencing stays in the top FSM.

## Test plan
- Reset, then ALU instruction: op=1, rd=3, ra=1, rb=2, fs=5, co=1 accepted at edge t.
  - Cycle t+1: A=1, B=2, FS=5, CO=1, wrt=0.
  - Cycle t+2: wrt=1, regSel=3, muxSelect=0, done=1.
  - `status` equals the `SIGNAL` value driven in cycle t+1 (e.g. 4'b0101).
- LOAD rd=7, ra=4 with RAM_LATENCY=2: wrt=1, regSel=7, muxSelect=1 exactly 4 cycles after the accept edge; RAMwrt stays 0 throughout.
- STORE ra=9, rb=10: RAMwrt=1 for exactly one cycle with A=9, B=10, done=1; instr_ready high the next cycle; wrt never asserted.
- Back-to-back: instr_valid held high with ALU, STORE, NOP queued. Retirements (done pulses) occur at t+2, t+4, t+6; no instruction is dropped or duplicated.
- Opcode 12: done=1 and illegal=1 in the same cycle, no enables asserted. HALT then asserts halted=1 and holds instr_ready=0 for 20 cycles; reset clears halted and restores ready.
- Reset asserted during WB of an ALU instruction: wrt=0 from the next cycle, no done pulse, status=0.
